// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared immediate-format selectors, RV opcode constants and
//                the elastic-buffer state encoding for the immediate pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Immediate format selector values carried on imm_src
    localparam logic [2:0] c_IMM_I     = 3'd0;
    localparam logic [2:0] c_IMM_S     = 3'd1;
    localparam logic [2:0] c_IMM_B     = 3'd2;
    localparam logic [2:0] c_IMM_J     = 3'd3;
    localparam logic [2:0] c_IMM_U     = 3'd4;
    localparam logic [2:0] c_IMM_SHAMT = 3'd5;
    localparam logic [2:0] c_IMM_ZIMM  = 3'd6;
    localparam logic [2:0] c_IMM_AUTO  = 3'd7;

    // Major opcodes (instr[6:0]) that carry an immediate
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // Occupancy of the two-entry output buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational RISC-V immediate extractor. Selects the format
//                explicitly or from the opcode (AUTO) and extends to XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic [2:0]      w_fmt;
    logic            w_err;
    logic [31:0]     w_imm32;
    logic            w_sext;
    logic            w_shamt_hi;
    logic [XLEN-1:0] w_imm_sext;
    logic [XLEN-1:0] w_imm_zext;

    // RV64 shift amounts are six bits wide; RV32 ignores instr[25]
    assign w_shamt_hi = (XLEN == 64) && instr[25];

    // Resolve the effective format; AUTO derives it from the opcode
    always_comb begin
        w_fmt = imm_src;
        w_err = 1'b0;
        if (imm_src == c_IMM_AUTO) begin
            case (instr[6:0])
                c_OP_LOAD, c_OP_IMM, c_OP_JALR: w_fmt = c_IMM_I;
                c_OP_STORE:                     w_fmt = c_IMM_S;
                c_OP_BRANCH:                    w_fmt = c_IMM_B;
                c_OP_JAL:                       w_fmt = c_IMM_J;
                c_OP_LUI, c_OP_AUIPC:           w_fmt = c_IMM_U;
                c_OP_SYSTEM:                    w_fmt = instr[14] ? c_IMM_ZIMM : c_IMM_I;
                default:                        w_err = 1'b1;
            endcase
        end
    end

    // Assemble the 32-bit immediate; an unresolved AUTO falls to zero
    always_comb begin
        w_imm32 = 32'd0;
        w_sext  = 1'b0;
        case (w_fmt)
            c_IMM_I: begin
                w_imm32 = {{20{instr[31]}}, instr[31:20]};
                w_sext  = 1'b1;
            end
            c_IMM_S: begin
                w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                w_sext  = 1'b1;
            end
            c_IMM_B: begin
                w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                w_sext  = 1'b1;
            end
            c_IMM_J: begin
                w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                w_sext  = 1'b1;
            end
            c_IMM_U: begin
                w_imm32 = {instr[31:12], 12'd0};
                w_sext  = 1'b1;
            end
            c_IMM_SHAMT: w_imm32 = {26'd0, w_shamt_hi, instr[24:20]};
            c_IMM_ZIMM:  w_imm32 = {27'd0, instr[19:15]};
            default:     w_imm32 = 32'd0;
        endcase
    end

    assign w_imm_sext = XLEN'($signed(w_imm32));
    assign w_imm_zext = XLEN'(w_imm32);
    assign imm        = w_sext ? w_imm_sext : w_imm_zext;
    assign err        = w_err;

endmodule : imm_decode
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Valid/ready wrapper around imm_decode with a two-entry
//                elastic output buffer (main + skid) and a saturating count
//                of illegal-format results delivered downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [2:0]           imm_src,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      imm_ext,
    output logic                 imm_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    buf_state_t           r_state;
    buf_state_t           w_state_nxt;
    logic                 r_in_ready;
    logic [XLEN-1:0]      r_main_imm;
    logic                 r_main_err;
    logic [XLEN-1:0]      r_skid_imm;
    logic                 r_skid_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [XLEN-1:0]      w_dec_imm;
    logic                 w_dec_err;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_load_main;
    logic                 w_load_skid;
    logic                 w_main_from_skid;

    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (w_dec_imm),
        .err     (w_dec_err)
    );

    // in_ready is registered, so TWO never sees an accept
    assign w_accept  = in_valid && r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_xfer    = out_valid && out_ready;

    // Buffer occupancy transitions and register load controls
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_xfer) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_xfer && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_xfer && w_accept) begin
                    w_load_main = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_xfer) begin
                    w_state_nxt      = ST_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register; in_ready tracks the upcoming state so it never depends on out_ready combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Main (head) and skid result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_imm <= '0;
            r_main_err <= 1'b0;
            r_skid_imm <= '0;
            r_skid_err <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_imm <= w_dec_imm;
                r_main_err <= w_dec_err;
            end else if (w_main_from_skid) begin
                r_main_imm <= r_skid_imm;
                r_main_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_imm <= w_dec_imm;
                r_skid_err <= w_dec_err;
            end
        end
    end

    // Saturating count of illegal results handed to the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_xfer && r_main_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign in_ready = r_in_ready;
    assign imm_ext  = r_main_imm;
    assign imm_err  = r_main_err;
    assign err_cnt  = r_err_cnt;

endmodule : imm_gen_pipe
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Directed self-checking bench for imm_gen_pipe, with one
//                XLEN=32 and one XLEN=64 instance sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;

    logic        r_in_valid32;
    logic [31:0] r_instr32;
    logic [2:0]  r_src32;
    logic        r_out_ready32;
    logic        w_in_ready32;
    logic        w_out_valid32;
    logic [31:0] w_imm32;
    logic        w_err32;
    logic [7:0]  w_cnt32;

    logic        r_in_valid64;
    logic [31:0] r_instr64;
    logic [2:0]  r_src64;
    logic        r_out_ready64;
    logic        w_in_ready64;
    logic        w_out_valid64;
    logic [63:0] w_imm64;
    logic        w_err64;
    logic [7:0]  w_cnt64;

    int n_vec = 0;
    int n_err = 0;

    imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(8)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_in_valid32),
        .in_ready  (w_in_ready32),
        .instr     (r_instr32),
        .imm_src   (r_src32),
        .out_valid (w_out_valid32),
        .out_ready (r_out_ready32),
        .imm_ext   (w_imm32),
        .imm_err   (w_err32),
        .err_cnt   (w_cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (r_in_valid64),
        .in_ready  (w_in_ready64),
        .instr     (r_instr64),
        .imm_src   (r_src64),
        .out_valid (w_out_valid64),
        .out_ready (r_out_ready64),
        .imm_ext   (w_imm64),
        .imm_err   (w_err64),
        .err_cnt   (w_cnt64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction through an idle instance with out_ready held high
    task automatic run_vec(input bit w64, input string tag, input logic [2:0] src,
                           input logic [31:0] ins, input logic [63:0] exp_imm,
                           input logic exp_err);
        if (w64) begin
            chk({tag, "_rdy"}, 64'(w_in_ready64), 64'd1);
            r_in_valid64 = 1'b1; r_instr64 = ins; r_src64 = src;
            tick();
            r_in_valid64 = 1'b0; r_instr64 = 32'h0;
            chk({tag, "_vld"}, 64'(w_out_valid64), 64'd1);
            chk({tag, "_imm"}, w_imm64, exp_imm);
            chk({tag, "_err"}, 64'(w_err64), 64'(exp_err));
        end else begin
            chk({tag, "_rdy"}, 64'(w_in_ready32), 64'd1);
            r_in_valid32 = 1'b1; r_instr32 = ins; r_src32 = src;
            tick();
            r_in_valid32 = 1'b0; r_instr32 = 32'h0;
            chk({tag, "_vld"}, 64'(w_out_valid32), 64'd1);
            chk({tag, "_imm"}, 64'(w_imm32), exp_imm);
            chk({tag, "_err"}, 64'(w_err32), 64'(exp_err));
        end
        tick();
    endtask

    initial begin
        bit flow_ok;

        rst_n = 1'b0;
        r_in_valid32 = 1'b0; r_instr32 = 32'h0; r_src32 = 3'd7; r_out_ready32 = 1'b1;
        r_in_valid64 = 1'b0; r_instr64 = 32'h0; r_src64 = 3'd0; r_out_ready64 = 1'b1;

        // Held in reset
        repeat (3) tick();
        chk("rst_vld",  64'(w_out_valid32), 64'd0);
        chk("rst_rdy",  64'(w_in_ready32),  64'd0);
        chk("rst_imm",  64'(w_imm32),       64'd0);
        chk("rst_err",  64'(w_err32),       64'd0);
        chk("rst_cnt",  64'(w_cnt32),       64'd0);

        // in_ready rises on the first edge after release
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_pre", 64'(w_in_ready32), 64'd0);
        tick();
        chk("rel_rdy32", 64'(w_in_ready32), 64'd1);
        chk("rel_rdy64", 64'(w_in_ready64), 64'd1);

        // XLEN=32 directed formats
        run_vec(1'b0, "addi",      3'd7, 32'hFFF00093, 64'hFFFFFFFF, 1'b0);
        run_vec(1'b0, "sw",        3'd7, 32'hFE112E23, 64'hFFFFFFFC, 1'b0);
        run_vec(1'b0, "lui",       3'd7, 32'h123452B7, 64'h12345000, 1'b0);
        run_vec(1'b0, "jal",       3'd7, 32'h001000EF, 64'h00000800, 1'b0);
        run_vec(1'b0, "beq",       3'd7, 32'hFE000EE3, 64'hFFFFFFFC, 1'b0);
        run_vec(1'b0, "csrrwi",    3'd7, 32'h300FD073, 64'h0000001F, 1'b0);
        run_vec(1'b0, "csrrw",     3'd7, 32'hFFF01073, 64'hFFFFFFFF, 1'b0);
        run_vec(1'b0, "s_expl",    3'd1, 32'hFFF00093, 64'hFFFFFFE1, 1'b0);
        run_vec(1'b0, "u_expl",    3'd4, 32'hFFF00093, 64'hFFF00000, 1'b0);
        run_vec(1'b0, "j_expl",    3'd3, 32'h001000EF, 64'h00000800, 1'b0);
        run_vec(1'b0, "shamt32",   3'd5, 32'h03F09093, 64'h0000001F, 1'b0);
        run_vec(1'b0, "zimm_expl", 3'd6, 32'h300FD073, 64'h0000001F, 1'b0);
        run_vec(1'b0, "bad_op",    3'd7, 32'h0000007F, 64'h00000000, 1'b1);
        chk("cnt_one", 64'(w_cnt32), 64'd1);

        // XLEN=64 directed formats
        run_vec(1'b1, "i64",     3'd0, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_vec(1'b1, "shamt64", 3'd5, 32'h03F09093, 64'h000000000000003F, 1'b0);
        run_vec(1'b1, "u64",     3'd4, 32'h800002B7, 64'hFFFFFFFF80000000, 1'b0);

        // Backpressure: two accepts fill the buffer, the third is held off
        r_out_ready32 = 1'b0;
        r_src32 = 3'd7;
        r_in_valid32 = 1'b1; r_instr32 = 32'hFFF00093;
        tick();
        chk("bp_rdy1", 64'(w_in_ready32), 64'd1);
        r_instr32 = 32'h123452B7;
        tick();
        r_instr32 = 32'h001000EF;
        chk("bp_rdy2",  64'(w_in_ready32),  64'd0);
        chk("bp_vld",   64'(w_out_valid32), 64'd1);
        chk("bp_head",  64'(w_imm32),       64'hFFFFFFFF);
        tick();
        chk("bp_hold_rdy", 64'(w_in_ready32), 64'd0);
        chk("bp_hold_imm", 64'(w_imm32),      64'hFFFFFFFF);
        r_out_ready32 = 1'b1;
        tick();
        chk("bp_drain1", 64'(w_imm32),      64'h12345000);
        chk("bp_rdy3",   64'(w_in_ready32), 64'd1);
        tick();
        r_in_valid32 = 1'b0;
        chk("bp_drain2", 64'(w_imm32),       64'h00000800);
        chk("bp_vld3",   64'(w_out_valid32), 64'd1);
        tick();
        chk("bp_empty",  64'(w_out_valid32), 64'd0);

        // Streaming illegal words: full throughput and saturating counter
        flow_ok = 1'b1;
        r_src32 = 3'd7; r_instr32 = 32'h0; r_in_valid32 = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (!w_out_valid32 || !w_in_ready32) flow_ok = 1'b0;
            if (i == 100) chk("cnt_mid", 64'(w_cnt32), 64'd100);
        end
        chk("sat_err", 64'(w_err32), 64'd1);
        chk("sat_imm", 64'(w_imm32), 64'd0);
        r_in_valid32 = 1'b0;
        tick();
        chk("sat_cnt",  64'(w_cnt32),       64'd255);
        chk("sat_flow", 64'(flow_ok),       64'd1);
        chk("sat_idle", 64'(w_out_valid32), 64'd0);

        // Reset asserted while the buffer holds two results
        r_out_ready32 = 1'b0;
        r_in_valid32 = 1'b1; r_instr32 = 32'hFFF00093;
        tick();
        r_instr32 = 32'h123452B7;
        tick();
        r_in_valid32 = 1'b0;
        chk("two_rdy", 64'(w_in_ready32),  64'd0);
        chk("two_vld", 64'(w_out_valid32), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(w_out_valid32), 64'd0);
        chk("arst_cnt", 64'(w_cnt32),       64'd0);
        chk("arst_rdy", 64'(w_in_ready32),  64'd0);
        chk("arst_imm", 64'(w_imm32),       64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("arel_rdy_pre", 64'(w_in_ready32), 64'd0);
        tick();
        chk("arel_rdy", 64'(w_in_ready32),  64'd1);
        chk("arel_vld", 64'(w_out_valid32), 64'd0);

        // Inputs are ignored while in_valid is low
        r_out_ready32 = 1'b1;
        r_instr32 = 32'h0000007F; r_src32 = 3'd7;
        tick();
        tick();
        chk("idle_vld", 64'(w_out_valid32), 64'd0);
        chk("idle_cnt", 64'(w_cnt32),       64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_imm_gen_pipe
`default_nettype wire
